pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Instruction-cycle controller for the 8-bit computer's program counter. It sequences the counter through fetch, decode, execute and update phases. It issues single-cycle increment or load commands to the counter, fetches the instruction byte at the counter's current value, and hands that byte to the execute unit. It sits between the program counter, instruction memory and the execute unit, and is the only block that drives the counter's control inputs.

## Interface
- WIDTH, 8: program counter width in bits
- RESET_VECTOR, 8'h00: address loaded into the counter after reset

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  start from IDLE, resume from HALT (level, sampled)
- halt_req  in  1  request halt at the next instruction boundary (level, sampled)
- pc_value  in  WIDTH  current counter value
- pc_inc  out  1  counter increment pulse
- pc_load  out  1  counter load pulse
- pc_load_val  out  WIDTH  counter load value, valid when pc_load=1
- mem_req  out  1  instruction fetch request
- mem_addr  out  WIDTH  fetch address
- mem_ack  in  1  fetch complete; mem_rdata valid this cycle
- mem_rdata  in  8  fetched instruction byte
- instr  out  8  last fetched instruction
- instr_valid  out  1  one-cycle pulse: instr is new
- exec_done  in  1  execute unit finished the current instruction
- branch_taken  in  1  sampled with exec_done
- branch_target  in  WIDTH  sampled with exec_done
- halted  out  1  high in HALT
- state  out  3  current state encoding, for debug

## Operation
- States and encodings: RST=0, VECTOR=1, IDLE=2, FETCH=3, DECODE=4, EXEC=5, UPDATE=6, HALT=7.
- All outputs are decoded from registered state and data registers. There is no input-to-output combinational path.
- RST → VECTOR → IDLE, unconditionally, one cycle each.
- VECTOR: pc_load=1, pc_load_val=RESET_VECTOR.
- IDLE:
  - halt_req=1 → HALT. halt_req takes priority over run.
  - Otherwise run=1 → FETCH.
- FETCH:
  - On entry, mem_addr latches pc_value.
  - mem_req stays high for the whole state.
  - When mem_ack=1, instr latches mem_rdata and the block goes to DECODE.
- DECODE: instr_valid=1 for this one cycle, then EXEC.
- EXEC:
  - Waits for exec_done=1.
  - On that cycle, branch_taken and branch_target are latched, then UPDATE.
  - exec_done is ignored in every other state.
- UPDATE:
  - If the latched branch flag is set: pc_load=1, pc_load_val=latched target.
  - Otherwise: pc_inc=1.
  - Next state: HALT if halt_req=1, otherwise FETCH.
- HALT:
  - halted=1.
  - run=1 with halt_req=0 → FETCH.
  - run=1 with halt_req=1 → stay in HALT.
- pc_inc and pc_load are never high together.
- halt_req asserted mid-instruction never aborts the fetch or execute; it is acted on only in IDLE, UPDATE or HALT.
- Counter wrap from all-ones to 0 is the counter's own behaviour; see Configuration.

## Timing
- Reset values:
  - state=RST.
  - pc_inc, pc_load, mem_req, instr_valid, halted = 0.
  - pc_load_val, mem_addr, instr = 0.
  - Latched branch flag and target = 0.
- Reset asserted mid-operation aborts immediately: mem_req drops asynchronously and nothing is pending after release.
- Reset release:
  - First clock edge: VECTOR, so pc_load is high in cycle 1.
  - Second edge: IDLE.
- Minimum instruction is 4 cycles (FETCH, DECODE, EXEC, UPDATE), with mem_ack and exec_done each high on the first cycle of their state.
  - Each cycle mem_ack is delayed adds one cycle.
  - Each cycle exec_done is delayed adds one cycle.
- The counter updates on the edge that ends UPDATE. The next FETCH therefore latches the updated pc_value.

## Configuration
- PC_WRAP_HALT_EN defined:
  - In UPDATE, a non-branch instruction with pc_value == all ones does not pulse pc_inc.
  - The block enters HALT instead; the counter holds all ones.
  - run=1 resumes with FETCH at all ones.
  - A taken branch at all ones loads normally.
- PC_WRAP_HALT_EN undefined: pc_inc is issued and the counter wraps to 0.

## Test plan
- Reset release, run=0 → pc_load=1 with pc_load_val=0x00 in cycle 1; state=IDLE from cycle 2; all other outputs 0.
- Straight-line instruction:
  - Stimulus: pc_value=0x05, run=1, mem_ack immediate with mem_rdata=0xA3, exec_done immediate with branch_taken=0.
  - Response: mem_addr=0x05; instr=0xA3 with instr_valid pulse; pc_inc pulse 4 cycles after FETCH entry.
- Branch with stalls:
  - Stimulus: mem_ack delayed 3 cycles; exec_done with branch_taken=1, branch_target=0x40.
  - Response: mem_req held 4 cycles; pc_load=1 with pc_load_val=0x40; next mem_addr=0x40.
- halt_req raised during EXEC → instruction completes with its pc_inc, then HALT with halted=1; run=1 with halt_req=0 → FETCH next cycle.
- pc_value=0xFF, non-branch instruction:
  - Macro undefined: pc_inc pulses, next mem_addr=0x00.
  - Macro defined: no pc_inc; HALT entered.
- Reset asserted mid-FETCH with mem_req=1 → mem_req=0 immediately; after release, VECTOR load repeats.

Source files
------------

// File: rtl/pc_sequencer.sv
// Instruction-cycle controller: fetch, decode, execute, update of the PC.
// Optional PC_WRAP_HALT_EN: halt instead of wrapping on a non-branch at all ones.
module pc_sequencer #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             halt_req,
  input  logic [WIDTH-1:0] pc_value,
  output logic             pc_inc,
  output logic             pc_load,
  output logic [WIDTH-1:0] pc_load_val,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [7:0]       mem_rdata,
  output logic [7:0]       instr,
  output logic             instr_valid,
  input  logic             exec_done,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  output logic             halted,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_VECTOR = 3'd1,
    S_IDLE   = 3'd2,
    S_FETCH  = 3'd3,
    S_DECODE = 3'd4,
    S_EXEC   = 3'd5,
    S_UPDATE = 3'd6,
    S_HALT   = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [7:0]       instr_q, instr_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic             wrap_stop;

`ifdef PC_WRAP_HALT_EN
  logic max_q;

  // PC is stable from FETCH to UPDATE, so its all-ones flag is captured early
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_q <= 1'b0;
    end else if (state_q == S_EXEC && exec_done) begin
      max_q <= &pc_value;
    end
  end

  assign wrap_stop = ~br_q & max_q;
`else
  assign wrap_stop = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RST;
      addr_q  <= '0;
      instr_q <= '0;
      br_q    <= 1'b0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      br_q    <= br_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    br_d    = br_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      S_RST:    state_d = S_VECTOR;
      S_VECTOR: state_d = S_IDLE;
      S_IDLE: begin
        if (halt_req) begin
          state_d = S_HALT;
        end else if (run) begin
          state_d = S_FETCH;
          addr_d  = pc_value;
        end
      end
      S_FETCH: begin
        if (mem_ack) begin
          instr_d = mem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (exec_done) begin
          br_d    = branch_taken;
          tgt_d   = branch_target;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if (wrap_stop || halt_req) begin
          state_d = S_HALT;
        end else begin
          // counter moves on this same edge; fetch from its new value
          state_d = S_FETCH;
          addr_d  = br_q ? tgt_q : pc_value + 1'b1;
        end
      end
      S_HALT: begin
        if (run && !halt_req) begin
          state_d = S_FETCH;
          addr_d  = pc_value;
        end
      end
    endcase
  end

  assign pc_inc      = (state_q == S_UPDATE) & ~br_q & ~wrap_stop;
  assign pc_load     = (state_q == S_VECTOR) |
                       ((state_q == S_UPDATE) & br_q);
  assign pc_load_val = (state_q == S_VECTOR) ? RESET_VECTOR :
                       ((state_q == S_UPDATE) & br_q) ? tgt_q : '0;
  assign mem_req     = (state_q == S_FETCH);
  assign mem_addr    = addr_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == S_DECODE);
  assign halted      = (state_q == S_HALT);
  assign state       = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: transaction-level instruction model,
// behavioural counter, directed plus randomized instructions.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       halt_req;
  logic [7:0] pc_value = 8'h77;
  logic       pc_inc;
  logic       pc_load;
  logic [7:0] pc_load_val;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic [7:0] instr;
  logic       instr_valid;
  logic       exec_done;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic       halted;
  logic [2:0] state;

  logic       preset_en = 1'b0;
  logic [7:0] preset_val = 8'h00;
  logic [7:0] exp_pc;
  int         compared = 0;
  int         mismatched = 0;
  bit         st;

  pc_sequencer #(.WIDTH(8), .RESET_VECTOR(8'h00)) dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .halt_req      (halt_req),
    .pc_value      (pc_value),
    .pc_inc        (pc_inc),
    .pc_load       (pc_load),
    .pc_load_val   (pc_load_val),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .exec_done     (exec_done),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halted        (halted),
    .state         (state)
  );

  always #5 clk = ~clk;

  // behavioural program counter
  always @(posedge clk) begin
    if (preset_en) pc_value <= preset_val;
    else if (pc_load) pc_value <= pc_load_val;
    else if (pc_inc) pc_value <= pc_value + 8'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("excl", {31'b0, pc_inc & pc_load}, 32'd0);
  endtask

  // one instruction from its first FETCH cycle to the cycle after UPDATE
  task automatic run_instr(input int da, input int de, input bit br,
                           input logic [7:0] tgt, input logic [7:0] rd,
                           input bit hreq, output bit stopped);
    bit wrap;
    chk("fetch_state", state, 3);
    chk("fetch_addr", mem_addr, exp_pc);
    chk("fetch_pc", pc_value, exp_pc);
    for (int i = 0; i < da; i++) begin
      mem_ack = 1'b0;
      mem_rdata = 8'($urandom);
      step();
      chk("fetch_hold", {state, mem_req}, {3'd3, 1'b1});
    end
    chk("fetch_req", mem_req, 1);
    mem_ack = 1'b1;
    mem_rdata = rd;
    step();
    mem_ack = 1'b0;
    chk("decode", {state, instr_valid, mem_req}, {3'd4, 1'b1, 1'b0});
    chk("instr", instr, rd);
    step();
    chk("exec", {state, instr_valid}, {3'd5, 1'b0});
    halt_req = hreq;
    for (int i = 0; i < de; i++) begin
      exec_done = 1'b0;
      branch_taken = 1'b1;
      branch_target = 8'($urandom);
      step();
      chk("exec_wait", state, 5);
    end
    exec_done = 1'b1;
    branch_taken = br;
    branch_target = tgt;
    step();
    exec_done = 1'b0;
    branch_taken = ~br;
    branch_target = ~tgt;
    wrap = 1'b0;
`ifdef PC_WRAP_HALT_EN
    wrap = !br && exp_pc == 8'hFF;
`endif
    chk("update", state, 6);
    if (br) chk("upd_load", {pc_inc, pc_load, pc_load_val}, {1'b0, 1'b1, tgt});
    else chk("upd_inc", {pc_inc, pc_load}, {!wrap, 1'b0});
    if (br) exp_pc = tgt;
    else if (!wrap) exp_pc = exp_pc + 8'd1;
    stopped = hreq || wrap;
    step();
    halt_req = 1'b0;
    chk("after_upd", {state, halted}, stopped ? {3'd7, 1'b1} : {3'd3, 1'b0});
    chk("pc_after", pc_value, exp_pc);
  endtask

  task automatic resume();
    run = 1'b1;
    halt_req = 1'b1;
    step();
    chk("halt_hold", {state, halted}, {3'd7, 1'b1});
    halt_req = 1'b0;
    step();
    run = 1'b0;
    chk("resume", {state, halted}, {3'd3, 1'b0});
  endtask

  initial begin
    reset = 1'b0;
    run = 1'b0;
    halt_req = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    exec_done = 1'b0;
    branch_taken = 1'b0;
    branch_target = 8'h00;
    #3;
    chk("rst_state", state, 0);
    chk("rst_ctl", {pc_inc, pc_load, mem_req, instr_valid, halted}, 0);
    chk("rst_data", {pc_load_val, mem_addr, instr}, 0);
    #9;
    reset = 1'b1;
    step();
    chk("vector", {state, pc_load, pc_inc, pc_load_val}, {3'd1, 1'b1, 1'b0, 8'h00});
    step();
    exp_pc = 8'h00;
    chk("idle", state, 2);
    chk("idle_outs", {pc_inc, pc_load, mem_req, instr_valid, halted}, 0);
    chk("idle_pc", pc_value, exp_pc);
    step();
    chk("idle_stay", state, 2);

    preset_en = 1'b1;
    preset_val = 8'h05;
    step();
    preset_en = 1'b0;
    exp_pc = 8'h05;
    run = 1'b1;
    halt_req = 1'b1;
    step();
    chk("idle_halt_prio", {state, halted}, {3'd7, 1'b1});
    halt_req = 1'b0;
    step();
    run = 1'b0;
    chk("halt_to_fetch", state, 3);

    run_instr(0, 0, 1'b0, 8'h00, 8'hA3, 1'b0, st);
    run_instr(3, 0, 1'b1, 8'h40, 8'h5C, 1'b0, st);
    run_instr(0, 1, 1'b0, 8'h00, 8'h11, 1'b1, st);
    chk("halt_flow", st, 1);
    resume();

    for (int n = 0; n < 40; n++) begin
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom), 8'($urandom), 8'($urandom),
                ($urandom_range(0, 5) == 0), st);
      if (st) resume();
    end

    run_instr(1, 0, 1'b1, 8'hFF, 8'h22, 1'b0, st);
    if (st) resume();
    run_instr(0, 2, 1'b0, 8'h00, 8'h33, 1'b0, st);
    if (st) resume();
    run_instr(0, 0, 1'b1, 8'h10, 8'h44, 1'b0, st);
    if (st) resume();

    chk("mid_fetch_req", mem_req, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst", {state, mem_req, instr}, 0);
    #2;
    reset = 1'b1;
    step();
    chk("vector2", {state, pc_load, pc_load_val}, {3'd1, 1'b1, 8'h00});
    step();
    exp_pc = 8'h00;
    chk("idle2", {state, mem_req}, {3'd2, 1'b0});
    run = 1'b1;
    step();
    run = 1'b0;
    run_instr(0, 0, 1'b0, 8'h00, 8'h99, 1'b0, st);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
